// File: rtl/action_sequencer_if.sv
// Game-sequencer boundary: judge feedback and game tick in, round descriptor and game status out.
interface action_sequencer_if;
  logic       tick;
  logic       start;
  logic [7:0] wrong_time;
  logic       level;
  logic [3:0] action;
  logic [7:0] count;
  logic       round_start;
  logic       game_over;
  logic       game_win;

  modport master (
    output tick, start, wrong_time,
    input  level, action, count, round_start, game_over, game_win
  );

  modport slave (
    input  tick, start, wrong_time,
    output level, action, count, round_start, game_over, game_win
  );
endinterface

// File: rtl/action_sequencer.sv
// Round sequencer for the button judge: paces rounds off the 10 Hz tick and draws a new direction each round.
// Outputs update on the edge that samples start/tick; no backpressure, the judge consumes every round.
module action_sequencer #(
  parameter int         TICKS_PER_ROUND = 40,
  parameter int         NUM_ROUNDS      = 20,
  parameter int         MAX_WRONG       = 5,
  parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  action_sequencer_if.slave  io
);

  // An all-zero Galois register would lock up, so a zero seed is remapped.
  localparam logic [7:0] SEED       = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [7:0] LAST_TICK  = 8'(TICKS_PER_ROUND - 1);
  localparam logic [7:0] LAST_ROUND = 8'(NUM_ROUNDS);
  localparam logic [7:0] WRONG_LIM  = 8'(MAX_WRONG);

  typedef enum logic [1:0] {IDLE, PLAY, LOSE, WIN} state_t;

  state_t     state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [7:0] tick_cnt_q, tick_cnt_d;
  logic [1:0] prev_q, prev_d;
  logic [3:0] action_q, action_d;
  logic [7:0] count_q, count_d;
  logic       round_start_q, round_start_d;
  logic [1:0] cand;
  logic       load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      lfsr_q        <= SEED;
      tick_cnt_q    <= 8'd0;
      prev_q        <= 2'd0;
      action_q      <= 4'd0;
      count_q       <= 8'd0;
      round_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      tick_cnt_q    <= tick_cnt_d;
      prev_q        <= prev_d;
      action_q      <= action_d;
      count_q       <= count_d;
      round_start_q <= round_start_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    tick_cnt_d    = tick_cnt_q;
    prev_d        = prev_q;
    action_d      = action_q;
    count_d       = count_q;
    round_start_d = 1'b0;
    load          = 1'b0;
    lfsr_d        = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);

    // Never repeat the previous direction back to back.
    cand = lfsr_q[1:0];
    if (cand == prev_q) begin
      cand = cand + 2'd1;
    end

    case (state_q)
      PLAY: begin
        if (io.start) begin
          count_d = 8'd1;
          load    = 1'b1;
        end else if (io.wrong_time >= WRONG_LIM) begin
          state_d = LOSE;
        end else if (io.tick) begin
          if (tick_cnt_q == LAST_TICK) begin
            if (count_q == LAST_ROUND) begin
              state_d = WIN;
            end else begin
              count_d = count_q + 8'd1;
              load    = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 8'd1;
          end
        end
      end
      default: begin
        if (io.start) begin
          state_d = PLAY;
          count_d = 8'd1;
          load    = 1'b1;
        end
      end
    endcase

    if (load) begin
      state_d       = PLAY;
      action_d      = {2'b00, cand};
      prev_d        = cand;
      tick_cnt_d    = 8'd0;
      round_start_d = 1'b1;
    end
  end

  assign io.level       = (state_q == PLAY);
  assign io.game_over   = (state_q == LOSE);
  assign io.game_win    = (state_q == WIN);
  assign io.action      = action_q;
  assign io.count       = count_q;
  assign io.round_start = round_start_q;

endmodule

// File: tb/tb_action_sequencer.sv
// Directed bench for action_sequencer with a cycle-level game model and literal spot checks.
module tb_action_sequencer;
  localparam int TICKS = 4;
  localparam int ROUNDS = 3;
  localparam int MAXW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   rs_seen = 0;

  action_sequencer_if io ();

  action_sequencer #(
    .TICKS_PER_ROUND(TICKS), .NUM_ROUNDS(ROUNDS), .MAX_WRONG(MAXW), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  always #5 clk = ~clk;

  // Game model: phase 0 idle, 1 playing, 2 lost, 3 won.
  int         m_phase, m_round, m_tick, m_prev, m_action, m_cand;
  bit         m_rs, m_load;
  logic [7:0] m_lfsr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_round = 0; m_tick = 0; m_prev = 0; m_action = 0; m_rs = 0;
      m_lfsr = 8'hA5;
    end else begin
      m_cand = m_lfsr % 4;
      if (m_cand == m_prev) m_cand = (m_cand + 1) % 4;
      m_load = 0;
      m_rs = 0;
      if (io.start) begin
        m_phase = 1; m_round = 1; m_load = 1;
      end else if (m_phase == 1) begin
        if (io.wrong_time >= MAXW) m_phase = 2;
        else if (io.tick) begin
          m_tick++;
          if (m_tick == TICKS) begin
            if (m_round == ROUNDS) m_phase = 3;
            else begin m_round++; m_load = 1; end
          end
        end
      end
      if (m_load) begin
        m_action = m_cand; m_prev = m_cand; m_tick = 0; m_rs = 1;
      end
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("m_level", int'(io.level), int'(m_phase == 1));
    check("m_game_over", int'(io.game_over), int'(m_phase == 2));
    check("m_game_win", int'(io.game_win), int'(m_phase == 3));
    check("m_action", int'(io.action), m_action);
    check("m_count", int'(io.count), m_round);
    check("m_round_start", int'(io.round_start), int'(m_rs));
    if (io.round_start) rs_seen++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    io.tick = 1'b1; step();
    io.tick = 1'b0; step();
  endtask

  task automatic pulse_start();
    io.start = 1'b1; step();
    io.start = 1'b0;
  endtask

  // Pulse start on the edge whose LFSR low bits equal want.
  task automatic start_on(input int want);
    bit hit;
    hit = 0;
    for (int k = 0; k < 600; k++) begin
      if (int'(m_lfsr[1:0]) == want) begin
        pulse_start();
        hit = 1;
        break;
      end
      step();
    end
    if (!hit) begin
      errors++;
      $display("FAIL start_on timeout: lfsr low bits never reached %0d", want);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_level"}, int'(io.level), 0);
    check({tag, "_action"}, int'(io.action), 0);
    check({tag, "_count"}, int'(io.count), 0);
    check({tag, "_rs"}, int'(io.round_start), 0);
    check({tag, "_over"}, int'(io.game_over), 0);
    check({tag, "_win"}, int'(io.game_win), 0);
  endtask

  int p;

  initial begin
    io.tick = 1'b0; io.start = 1'b0; io.wrong_time = 8'd0;
    repeat (3) step();
    check_zero("reset");
    rst = 1'b0;
    // LFSR walks A5, EA, 75, 82 while idle; start lands on 41.
    for (int i = 0; i < 4; i++) begin
      io.tick = (i % 2 == 1);
      step();
    end
    io.tick = 1'b0;
    check("idle_level", int'(io.level), 0);
    check("idle_count", int'(io.count), 0);

    rs_seen = 0;
    pulse_start();
    check("start_level", int'(io.level), 1);
    check("start_count", int'(io.count), 1);
    check("start_rs", int'(io.round_start), 1);
    check("start_action", int'(io.action), 1);
    step();
    check("rs_one_cycle", int'(io.round_start), 0);

    repeat (4) pulse_tick();
    check("round2_count", int'(io.count), 2);
    check("round2_new_action", int'(io.action != 4'd1), 1);
    check("action_hi_zero", int'(io.action[3:2]), 0);

    repeat (8) pulse_tick();
    check("win_flag", int'(io.game_win), 1);
    check("win_level", int'(io.level), 0);
    check("win_count", int'(io.count), 3);
    check("win_rs_total", rs_seen, 3);

    // Candidate collides with previous direction.
    p = m_prev;
    start_on(p);
    check("collide_action", int'(io.action), (p + 1) % 4);
    check("collide_rs", int'(io.round_start), 1);
    if (m_prev != 3) start_on(3);
    check("prev_is_3", int'(io.action), 3);
    start_on(3);
    check("wrap_action", int'(io.action), 0);

    // Loss coincides with the round-advance tick.
    repeat (3) pulse_tick();
    io.tick = 1'b1; io.wrong_time = 8'd5; step();
    io.tick = 1'b0;
    check("lose_over", int'(io.game_over), 1);
    check("lose_level", int'(io.level), 0);
    check("lose_count", int'(io.count), 1);
    check("lose_rs", int'(io.round_start), 0);
    io.wrong_time = 8'd0;
    step();
    pulse_start();
    check("restart_count", int'(io.count), 1);
    check("restart_level", int'(io.level), 1);
    check("restart_over", int'(io.game_over), 0);

    repeat (4) pulse_tick();
    check("pre_rst_count", int'(io.count), 2);
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    repeat (2) step();
    rst = 1'b0;
    repeat (3) step();
    check("post_rst_level", int'(io.level), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/action_sequencer.md
Name: action_sequencer

Overview:
- Upstream stage of the 4-second button judge.
- Runs the game's round sequence and produces `level`, `action` and `count` for the judge.
- Starts a new round every TICKS_PER_ROUND ticks of the 10 Hz game tick; each round carries a fresh pseudo-random direction code.
- Ends the game on a win (all rounds played) or a loss (judge's `wrong_time` reaches MAX_WRONG).

Parameters:
- TICKS_PER_ROUND, 40: 10 Hz ticks per round window (40 = 4 s).
- NUM_ROUNDS, 20: rounds per game; final value of `count` on a win.
- MAX_WRONG, 5: `wrong_time` value that ends the game as a loss.
- LFSR_SEED, 8'hA5: LFSR reset value; a value of 0 is replaced by 8'h01.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- tick  in  1  one-clk-wide pulse, 10 Hz game tick
- start  in  1  one-clk pulse; begins or restarts a game
- wrong_time  in  8  error count fed back from the judge
- level  out  1  1 while a game is being played (judge enable)
- action  out  4  required move: 4'b0000 up, 4'b0001 down, 4'b0010 left, 4'b0011 right
- count  out  8  current round number, 1..NUM_ROUNDS
- round_start  out  1  one-clk pulse when a new `action` becomes valid
- game_over  out  1  high in the LOSE state
- game_win  out  1  high in the WIN state

Behaviour:
- Reset: asynchronous, active-high. State=IDLE, lfsr=LFSR_SEED, tick_cnt=0, prev=0. All outputs 0.
- LFSR:
  - 8-bit Galois, right-shift, mask 8'hB8.
  - Advances every clk in which rst is low, in every state.
- Candidate action each cycle:
  - c = lfsr[1:0].
  - If c == prev[1:0], use c+1 mod 4.
  - action = {2'b00, c_final}.
- Load action (one clk edge):
  - action <= candidate; prev <= candidate.
  - tick_cnt <= 0.
  - round_start <= 1 for exactly the next cycle.
- States:
  - IDLE: level=0.
    - start -> PLAY; count<=1; load action.
  - PLAY: level=1. Checked each clk, in this priority order:
    1. wrong_time >= MAX_WRONG -> LOSE. Action and count hold; no further round_start.
    2. tick && tick_cnt == TICKS_PER_ROUND-1 && count == NUM_ROUNDS -> WIN.
    3. tick && tick_cnt == TICKS_PER_ROUND-1 -> count<=count+1; load action.
    4. tick -> tick_cnt<=tick_cnt+1.
  - A start pulse during PLAY restarts the game: count<=1; load action.
  - LOSE: level=0; game_over=1.
  - WIN: level=0; game_win=1.
  - LOSE and WIN hold count and action until start. Start -> PLAY; count<=1; load action.
- Simultaneous events:
  - start with tick: start wins; the tick is ignored.
  - start with rst: rst wins.
  - The loss check in PLAY takes priority over round advance in the same cycle.
- Widths:
  - tick_cnt is 8 bits; TICKS_PER_ROUND must be ≤ 255.
  - count never wraps; it saturates at NUM_ROUNDS via the WIN transition.
- Reset mid-game: returns immediately to IDLE with all outputs 0.
- Latency:
  - action, count and round_start change on the clk edge that samples the triggering start or tick.
  - level rises on that same edge.

Test Plan:
- Reset with TICKS=4, ROUNDS=3, MAX_WRONG=5 -> all outputs 0; state stays IDLE with no start, even while tick toggles.
- Start pulse -> next cycle level=1, count=1, round_start=1 for one cycle. Action equals the reference-model candidate from lfsr at that edge; action[3:2]=0.
- 4 ticks -> count=2 with a new action ≠ the previous one; 8 further ticks -> game_win=1, level=0, count=3. Exactly 3 round_start pulses in total.
- Force lfsr so that candidate equals prev (model-driven) -> action = prev+1 mod 4. Check the wrap case: prev=3 gives 0.
- wrong_time=5 arriving in the same cycle as the round-advance tick -> game_over=1, count holds at its current value, no round_start pulse.
- Assert rst mid-PLAY (count=2) -> outputs 0 asynchronously. Start from LOSE -> count=1, level=1.
